// File: rtl/led_sequencer.sv
// Pattern controller for five active-low status LEDs: prescaled step tick,
// tick-aligned mode changes via valid/ready, and global PWM brightness gating.
module led_sequencer #(
  parameter int TICK_DIV = 4096,
  parameter int PWM_W    = 4
) (
  input  logic             clkin,
  input  logic             rstnin,
  input  logic             mode_valid,
  input  logic [1:0]       mode_sel,
  output logic             mode_ready,
  input  logic [4:0]       pattern,
  input  logic [PWM_W-1:0] bright,
  output logic [4:0]       ledout,
  output logic             step_tick,
  output logic [1:0]       cur_mode
);

  localparam int              CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(TICK_DIV - 1);

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_STATIC = 2'd1;
  localparam logic [1:0] MODE_COUNT  = 2'd2;
  localparam logic [1:0] MODE_SCAN   = 2'd3;

  typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_e;

  logic [CNT_W-1:0] presc_r;
  logic             step_tick_r;
  state_e           state_r;
  state_e           state_nx_s;
  logic             mode_ready_s;
  logic             accept_s;
  logic             apply_s;
  logic             advance_s;
  logic [1:0]       pend_mode_r;
  logic [1:0]       cur_mode_r;
  logic [4:0]       count_r;
  logic [2:0]       pos_r;
  logic [2:0]       pos_nx_s;
  logic             dir_r;
  logic [4:0]       raw_s;
  logic [PWM_W-1:0] pwm_cnt_r;
  logic             pwm_on_s;
  logic [4:0]       ledout_r;

  // Prescaler and registered step pulse, one cycle after the counter's last value
  always_ff @(posedge clkin or negedge rstnin) begin
    if (!rstnin) begin
      presc_r     <= '0;
      step_tick_r <= 1'b0;
    end else begin
      if (presc_r == DIV_LAST) begin
        presc_r <= '0;
      end else begin
        presc_r <= presc_r + CNT_W'(1);
      end
      step_tick_r <= (presc_r == DIV_LAST);
    end
  end

  // Mode FSM state register
  always_ff @(posedge clkin or negedge rstnin) begin
    if (!rstnin) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Mode FSM next state; a tick in the handshake cycle is seen while still IDLE
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mode_valid) begin
          state_nx_s = ST_PEND;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (step_tick_r) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_PEND;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Mode FSM outputs
  always_comb begin
    mode_ready_s = 1'b0;
    accept_s     = 1'b0;
    apply_s      = 1'b0;
    advance_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        mode_ready_s = 1'b1;
        accept_s     = mode_valid;
        advance_s    = step_tick_r;
      end
      ST_PEND: begin
        apply_s = step_tick_r;
      end
      default: begin
        mode_ready_s = 1'b0;
      end
    endcase
  end

  // Pending request capture
  always_ff @(posedge clkin or negedge rstnin) begin
    if (!rstnin) begin
      pend_mode_r <= MODE_OFF;
    end else if (accept_s) begin
      pend_mode_r <= mode_sel;
    end else begin
      pend_mode_r <= pend_mode_r;
    end
  end

  // Bounce step: reverse direction is applied when the new position hits an end
  always_comb begin
    pos_nx_s = pos_r;
    if (dir_r) begin
      pos_nx_s = pos_r - 3'd1;
    end else begin
      pos_nx_s = pos_r + 3'd1;
    end
  end

  // Applied mode and pattern state
  always_ff @(posedge clkin or negedge rstnin) begin
    if (!rstnin) begin
      cur_mode_r <= MODE_OFF;
      count_r    <= 5'd0;
      pos_r      <= 3'd0;
      dir_r      <= 1'b0;
    end else if (apply_s) begin
      cur_mode_r <= pend_mode_r;
      count_r    <= 5'd0;
      pos_r      <= 3'd0;
      dir_r      <= 1'b0;
    end else if (advance_s) begin
      case (cur_mode_r)
        MODE_COUNT: count_r <= count_r + 5'd1;
        MODE_SCAN: begin
          pos_r <= pos_nx_s;
          if (pos_nx_s == 3'd4) begin
            dir_r <= 1'b1;
          end else if (pos_nx_s == 3'd0) begin
            dir_r <= 1'b0;
          end else begin
            dir_r <= dir_r;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end else begin
      cur_mode_r <= cur_mode_r;
    end
  end

  // Raw lit vector per mode
  always_comb begin
    raw_s = 5'd0;
    case (cur_mode_r)
      MODE_OFF:    raw_s = 5'd0;
      MODE_STATIC: raw_s = pattern;
      MODE_COUNT:  raw_s = count_r;
      MODE_SCAN:   raw_s = 5'b00001 << pos_r;
      default:     raw_s = 5'd0;
    endcase
  end

  assign pwm_on_s = (bright == {PWM_W{1'b1}}) || (pwm_cnt_r < bright);

  // Free-running PWM counter and registered active-low LED drive
  always_ff @(posedge clkin or negedge rstnin) begin
    if (!rstnin) begin
      pwm_cnt_r <= '0;
      ledout_r  <= 5'b11111;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + PWM_W'(1);
      ledout_r  <= ~(raw_s & {5{pwm_on_s}});
    end
  end

  assign mode_ready = mode_ready_s;
  assign step_tick  = step_tick_r;
  assign cur_mode   = cur_mode_r;
  assign ledout     = ledout_r;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with TICK_DIV=4: tick timing, COUNT/SCAN/
// STATIC patterns, PWM duty, tick-coincident handshake and reset while pending.
module tb_led_sequencer;

  logic       clkin;
  logic       rstnin;
  logic       mode_valid;
  logic [1:0] mode_sel;
  logic       mode_ready;
  logic [4:0] pattern;
  logic [3:0] bright;
  logic [4:0] ledout;
  logic       step_tick;
  logic [1:0] cur_mode;

  int total = 0;
  int bad   = 0;

  led_sequencer #(.TICK_DIV(4), .PWM_W(4)) dut (
    .clkin     (clkin),
    .rstnin    (rstnin),
    .mode_valid(mode_valid),
    .mode_sel  (mode_sel),
    .mode_ready(mode_ready),
    .pattern   (pattern),
    .bright    (bright),
    .ledout    (ledout),
    .step_tick (step_tick),
    .cur_mode  (cur_mode)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns at the first falling edge where step_tick is high.
  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 16 && !seen; n++) begin
      @(negedge clkin);
      if (step_tick) seen = 1'b1;
    end
    chk("tick_seen", 32'(seen), 32'd1);
  endtask

  task automatic count_pwm(input int want_lit, input logic [4:0] lit_val);
    int lit;
    int dark;
    lit  = 0;
    dark = 0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clkin);
      if (ledout === lit_val) lit++;
      else if (ledout === 5'b11111) dark++;
    end
    chk("pwm_lit", 32'(lit), 32'(want_lit));
    chk("pwm_dark", 32'(dark), 32'(16 - want_lit));
  endtask

  logic [4:0] scan_exp [10] = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111,
                                5'b10111, 5'b11011, 5'b11101, 5'b11110, 5'b11101};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] cexp;
    rstnin     = 1'b0;
    mode_valid = 1'b0;
    mode_sel   = 2'd0;
    pattern    = 5'b10101;
    bright     = 4'hF;
    repeat (3) @(negedge clkin);
    chk("rst_ledout", 32'(ledout), 32'h1F);
    chk("rst_mode", 32'(cur_mode), 32'd0);
    chk("rst_ready", 32'(mode_ready), 32'd1);
    chk("rst_tick", 32'(step_tick), 32'd0);

    rstnin = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clkin);
      chk("tick_period", 32'(step_tick), (k % 4 == 0) ? 32'd1 : 32'd0);
    end
    chk("idle_ledout", 32'(ledout), 32'h1F);

    // COUNT request away from a tick
    @(negedge clkin);
    mode_valid = 1'b1;
    mode_sel   = 2'd2;
    @(negedge clkin);
    mode_valid = 1'b0;
    chk("cnt_ready_low", 32'(mode_ready), 32'd0);
    wait_tick();
    chk("cnt_not_yet", 32'(cur_mode), 32'd0);
    @(negedge clkin);
    chk("cnt_mode", 32'(cur_mode), 32'd2);
    chk("cnt_ready_back", 32'(mode_ready), 32'd1);
    for (int i = 0; i <= 32; i++) begin
      wait_tick();
      cexp = 5'(i);
      cexp = ~cexp;
      chk("cnt_led", 32'(ledout), 32'(cexp));
    end

    // SCAN
    @(negedge clkin);
    mode_valid = 1'b1;
    mode_sel   = 2'd3;
    @(negedge clkin);
    mode_valid = 1'b0;
    wait_tick();
    for (int i = 0; i < 10; i++) begin
      wait_tick();
      chk("scan_led", 32'(ledout), 32'(scan_exp[i]));
    end
    chk("scan_mode", 32'(cur_mode), 32'd3);

    // STATIC with PWM brightness
    @(negedge clkin);
    mode_valid = 1'b1;
    mode_sel   = 2'd1;
    @(negedge clkin);
    mode_valid = 1'b0;
    wait_tick();
    @(negedge clkin);
    chk("static_mode", 32'(cur_mode), 32'd1);
    bright = 4'd4;
    repeat (3) @(negedge clkin);
    count_pwm(4, 5'b01010);
    bright = 4'd0;
    repeat (3) @(negedge clkin);
    count_pwm(0, 5'b01010);
    bright = 4'hF;
    repeat (3) @(negedge clkin);
    count_pwm(16, 5'b01010);

    // Handshake coinciding with step_tick, second request held while pending
    wait_tick();
    mode_valid = 1'b1;
    mode_sel   = 2'd2;
    @(negedge clkin);
    mode_sel = 2'd3;
    chk("coin_ready_low", 32'(mode_ready), 32'd0);
    chk("coin_not_applied", 32'(cur_mode), 32'd1);
    wait_tick();
    chk("coin_still_static", 32'(cur_mode), 32'd1);
    chk("coin_second_held", 32'(mode_ready), 32'd0);
    @(negedge clkin);
    chk("coin_applied", 32'(cur_mode), 32'd2);
    chk("coin_ready_back", 32'(mode_ready), 32'd1);
    @(negedge clkin);
    chk("second_accepted", 32'(mode_ready), 32'd0);
    mode_valid = 1'b0;
    wait_tick();
    @(negedge clkin);
    chk("second_mode", 32'(cur_mode), 32'd3);

    // Reset while PENDING with SCAN at position 3
    repeat (4) wait_tick();
    chk("scan_pos3", 32'(ledout), 32'h17);
    @(negedge clkin);
    mode_valid = 1'b1;
    mode_sel   = 2'd1;
    @(negedge clkin);
    mode_valid = 1'b0;
    chk("pend_ready_low", 32'(mode_ready), 32'd0);
    #1;
    rstnin = 1'b0;
    #1;
    chk("async_ledout", 32'(ledout), 32'h1F);
    chk("async_mode", 32'(cur_mode), 32'd0);
    chk("async_ready", 32'(mode_ready), 32'd1);
    repeat (2) @(negedge clkin);
    rstnin = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clkin);
      chk("rel_tick", 32'(step_tick), (k % 4 == 0) ? 32'd1 : 32'd0);
    end
    chk("rel_mode", 32'(cur_mode), 32'd0);
    chk("rel_ledout", 32'(ledout), 32'h1F);
    chk("rel_ready", 32'(mode_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Pattern controller for the board's five active-low status LEDs; replaces the free-running divider taps with a host-selectable pattern.
- Free-running prescaler generates a step tick.
- Mode FSM accepts mode-change requests through a valid/ready handshake and applies them only on tick boundaries, so LEDs never glitch mid-step.
- Per-LED PWM gating provides global brightness control. Sits between host/config logic and the LED pins.

Parameters:
- TICK_DIV, 4096: clocks per pattern step; legal range 2 to 2^24.
- PWM_W, 4: width of brightness value and PWM counter.

Ports:
- clkin  in  1  system clock; all logic on rising edge.
- rstnin  in  1  asynchronous active-low reset; deassertion synchronous to clkin externally.
- mode_valid  in  1  mode-change request valid.
- mode_sel  in  2  requested mode: 0 OFF, 1 STATIC, 2 COUNT, 3 SCAN.
- mode_ready  out  1  request acceptance; a transfer occurs when mode_valid and mode_ready are both high.
- pattern  in  5  STATIC-mode LED pattern, 1 = lit; sampled live, not latched.
- bright  in  PWM_W  global brightness duty; sampled live.
- ledout  out  5  LED drive, active low (0 = lit), registered.
- step_tick  out  1  one-cycle pulse at each pattern step, registered.
- cur_mode  out  2  mode currently applied.

Behaviour:
- Reset values (asynchronous, while rstnin = 0):
  - prescaler = 0, step_tick = 0, PWM counter = 0.
  - cur_mode = OFF, mode_ready = 1, FSM = IDLE.
  - count = 0, scan position = 0, scan direction = up.
  - ledout = 5'b11111 (all off).
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - step_tick is high for exactly the cycle after the prescaler holds TICK_DIV-1, i.e. period TICK_DIV, first pulse at cycle TICK_DIV after reset release.
- FSM states IDLE and PENDING:
  - IDLE: mode_ready = 1. On handshake, latch mode_sel into pend_mode and go to PENDING; mode_ready drops the next cycle.
  - PENDING: mode_ready = 0; mode_valid is ignored.
  - On the first step_tick seen in PENDING: cur_mode <= pend_mode; count <= 0; scan position <= 0; scan direction <= up; return to IDLE. That tick does not advance the pattern.
  - If the handshake cycle coincides with step_tick, that tick is not used; the mode applies at the following tick.
  - A request for the already-active mode is accepted and restarts that pattern state.
- Pattern state, advanced only on step_tick while IDLE:
  - COUNT: 5-bit count += 1, wrapping 31 -> 0.
  - SCAN: position bounces 0,1,2,3,4,3,2,1,0,1,... Direction flips to down when position reaches 4 and to up when it reaches 0, with no dwell at the ends.
  - OFF and STATIC: pattern state is held.
- Raw lit vector:
  - OFF = 0.
  - STATIC = pattern.
  - COUNT = count.
  - SCAN = one-hot, bit[position].
- PWM:
  - PWM_W-bit counter free-runs every clock and wraps.
  - pwm_on = (pwm_cnt < bright), or forced 1 when bright is all-ones.
  - bright = 0 gives all LEDs dark; all-ones gives fully on.
- Output: ledout <= ~(raw & {5{pwm_on}}), registered. One clock latency from state/pattern/bright change to ledout.
- Reset mid-operation: any pending request is discarded; returns to the reset values above.

Test Plan:
- Reset release, TICK_DIV=4, no requests -> ledout = 11111, cur_mode = 0, mode_ready = 1, step_tick pulses every 4 clocks starting at cycle 4.
- Request COUNT (mode_valid=1, mode_sel=2), bright=4'hF -> mode_ready low until the next tick, then cur_mode = 2. On successive ticks ledout = 11111, 11110, 11101, 11100, ...; after 32 steps it wraps to 11111.
- Request SCAN, bright=4'hF -> over 10 ticks the lit bit index is 0,1,2,3,4,3,2,1,0,1 (ledout 11110, 11101, ... , 01111, 10111, ...).
- STATIC with pattern = 10101, bright = 4 -> over 16 clocks ledout = 01010 for exactly 4 clocks and 11111 for 12; bright = 0 -> constant 11111.
- Handshake in the same cycle as step_tick, with a second mode_valid held during PENDING -> mode applied at the next tick only; the second request is not accepted until mode_ready returns high.
- Reset asserted while PENDING in SCAN position 3 -> ledout = 11111 immediately (asynchronous); after release cur_mode = 0 and the pending request is lost.
